// File: rtl/cpu_bus_pkg.sv
// Shared identifiers for the BRAM port arbiter: requester ids, owner encoding,
// lock FSM state encoding and a small one-hot helper.
package cpu_bus_pkg;

  localparam int         NUM_REQ    = 3;
  localparam logic [1:0] REQ_FETCH  = 2'd0;
  localparam logic [1:0] REQ_DATA   = 2'd1;
  localparam logic [1:0] REQ_PERIPH = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  // OWNER_NONE maps to an empty mask so it can never select a requester.
  function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      REQ_FETCH:  oh = 3'b001;
      REQ_DATA:   oh = 3'b010;
      REQ_PERIPH: oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: scans from ptr+1 (mod 3) and
// returns the first eligible id; any_o is low when nothing is eligible.
module rr_pick3 (
  input  logic [2:0] eligible_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] win_o,
  output logic       any_o
);

  logic [1:0] first_id;
  logic [1:0] second_id;
  logic [1:0] third_id;

  // ptr 3 never occurs; it falls into the same order as ptr 2.
  always_comb begin
    case (ptr_i)
      2'd0: begin
        first_id  = 2'd1;
        second_id = 2'd2;
        third_id  = 2'd0;
      end
      2'd1: begin
        first_id  = 2'd2;
        second_id = 2'd0;
        third_id  = 2'd1;
      end
      default: begin
        first_id  = 2'd0;
        second_id = 2'd1;
        third_id  = 2'd2;
      end
    endcase
  end

  always_comb begin
    any_o = |eligible_i;
    if (eligible_i[first_id]) begin
      win_o = first_id;
    end else if (eligible_i[second_id]) begin
      win_o = second_id;
    end else begin
      win_o = third_id;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A among fetch, load/store and peripheral requesters with
// round-robin arbitration, a bounded ownership lock and routed read data.
module bram_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [2:0]            req_lock,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  output logic                  bram_we,
  input  logic [DATA_W-1:0]     bram_q,
  output logic [1:0]            owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e       state_q, state_d;
  logic [1:0]        lock_id_q, lock_id_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              no_relock_q, no_relock_d;

  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_wdata_q;
  logic              bram_we_q;
  logic              tag1_vld_q, tag2_vld_q;
  logic [1:0]        tag1_id_q, tag2_id_q;

  logic [2:0]        eligible;
  logic [1:0]        win;
  logic [2:0]        win_oh;
  logic              any_req;
  logic              accept;
  logic              win_we;
  logic              win_lock;
  logic              owner_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // While locked, only the owner may compete, even when it is idle.
  assign eligible = (state_q == LK_LOCKED) ? (req & id_to_onehot(lock_id_q)) : req;

  rr_pick3 u_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .win_o      (win),
    .any_o      (any_req)
  );

  assign accept     = any_req & reset;
  assign win_oh     = id_to_onehot(win);
  assign win_we     = |(req_we & win_oh);
  assign win_lock   = |(req_lock & win_oh);
  assign owner_lock = |(req_lock & id_to_onehot(lock_id_q));
  assign win_addr   = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign win_wdata  = req_wdata[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LK_UNLOCKED;
      lock_id_q   <= OWNER_NONE;
      lock_cnt_q  <= '0;
      rr_ptr_q    <= REQ_PERIPH;
      no_relock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      lock_cnt_q  <= lock_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      no_relock_q <= no_relock_d;
    end
  end

  // After a forced release rr_ptr_q still names the old owner until the next
  // accept, so it doubles as the id barred from re-locking for that round.
  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    lock_cnt_d  = lock_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    no_relock_d = no_relock_q;
    if (accept) begin
      rr_ptr_d    = win;
      no_relock_d = 1'b0;
    end
    case (state_q)
      LK_UNLOCKED: begin
        if (accept && win_lock && !(no_relock_q && (win == rr_ptr_q))) begin
          state_d    = LK_LOCKED;
          lock_id_d  = win;
          lock_cnt_d = CNT_W'(1);
        end
      end
      LK_LOCKED: begin
        if (!owner_lock || (lock_cnt_q == CNT_W'(LOCK_MAX))) begin
          state_d     = LK_UNLOCKED;
          lock_id_d   = OWNER_NONE;
          lock_cnt_d  = '0;
          rr_ptr_d    = lock_id_q;
          no_relock_d = owner_lock;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LK_UNLOCKED;
      end
    endcase
  end

  always_comb begin
    gnt    = accept ? win_oh : 3'b000;
    owner  = (state_q == LK_LOCKED) ? lock_id_q : OWNER_NONE;
    rvalid = tag2_vld_q ? id_to_onehot(tag2_id_q) : 3'b000;
    rdata  = tag2_vld_q ? bram_q : '0;
  end

  // Issue registers hold the last address when idle; the tag pipe lines up
  // with the BRAM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= 1'b0;
      tag1_vld_q   <= 1'b0;
      tag1_id_q    <= 2'd0;
      tag2_vld_q   <= 1'b0;
      tag2_id_q    <= 2'd0;
    end else begin
      bram_we_q  <= accept & win_we;
      tag1_vld_q <= accept & ~win_we;
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
      if (accept) begin
        bram_addr_q  <= win_addr;
        bram_wdata_q <= win_wdata;
        tag1_id_q    <= win;
      end
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign bram_we    = bram_we_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference model with a shadow memory.
module tb_bram_port_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, req_we, req_lock;
  logic [47:0] req_addr, req_wdata;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, bram_addr, bram_wdata, bram_q;
  logic        bram_we;
  logic [1:0]  owner;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_we(bram_we), .bram_q(bram_q), .owner(owner)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM port A model, read-before-write, with a preload path used in reset
  logic [15:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_we) mem[bram_addr[9:0]] <= bram_wdata;
    bram_q <= mem[bram_addr[9:0]];
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // requester drivers
  logic [2:0]  p_vld, p_we, lk;
  logic [15:0] p_addr [3];
  logic [15:0] p_wdata [3];

  task automatic post(input int id, input logic we, input logic lock,
                      input logic [15:0] addr, input logic [15:0] wd);
    p_vld[id] = 1'b1;
    p_we[id] = we;
    lk[id] = lock;
    p_addr[id] = addr;
    p_wdata[id] = wd;
  endtask

  task automatic post_rand(input int id);
    logic [15:0] a;
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) a = 16'h0010;
    else if (r == 1) a = 16'h0200;
    else a = 16'($urandom_range(0, 31));
    post(id, 1'($urandom_range(0, 1)), lk[id], a, 16'($urandom_range(0, 65535)));
  endtask

  // reference model: transaction-level view of ownership and rotation
  logic [15:0] ref_mem [0:1023];
  logic [49:0] exp_q [$];
  int          m_last, m_owner, m_lk_cycles, m_norelock_id;
  logic        m_locked, m_norelock, m_prev_we;
  logic [15:0] m_prev_addr, m_prev_wdata;
  logic [2:0]  obs_gnt;
  logic [1:0]  obs_owner;

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'((i * 40503) ^ 16'h1234);
  endfunction

  task automatic model_reset();
    m_last = 2;
    m_owner = 3;
    m_lk_cycles = 0;
    m_locked = 1'b0;
    m_norelock = 1'b0;
    m_norelock_id = 3;
    m_prev_we = 1'b0;
    m_prev_addr = 16'h0;
    m_prev_wdata = 16'h0;
    exp_q.delete();
    p_vld = 3'b000;
    lk = 3'b000;
  endtask

  task automatic model_cycle();
    int win;
    int c;
    logic [2:0] exp_gnt, exp_rv;
    logic [15:0] exp_rd;
    logic [49:0] e;
    win = -1;
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (win < 0 && p_vld[c] && (!m_locked || c == m_owner)) win = c;
    end
    exp_gnt = (win >= 0) ? (3'b001 << win) : 3'b000;
    obs_gnt = gnt;
    obs_owner = owner;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("owner", 32'(owner), m_locked ? 32'(m_owner) : 32'd3);
    chk("bram_we", 32'(bram_we), 32'(m_prev_we));
    chk("bram_addr", 32'(bram_addr), 32'(m_prev_addr));
    if (m_prev_we) chk("bram_wdata", 32'(bram_wdata), 32'(m_prev_wdata));
    exp_rv = 3'b000;
    exp_rd = 16'h0;
    if (exp_q.size() > 0 && exp_q[0][49:18] == 32'(cyc)) begin
      e = exp_q.pop_front();
      exp_rv = 3'b001 << e[17:16];
      exp_rd = e[15:0];
    end
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != 3'b000) chk("rdata", 32'(rdata), 32'(exp_rd));

    m_prev_we = 1'b0;
    if (win >= 0) begin
      m_prev_addr = p_addr[win];
      m_prev_wdata = p_wdata[win];
      if (p_we[win]) begin
        ref_mem[p_addr[win][9:0]] = p_wdata[win];
        m_prev_we = 1'b1;
      end else begin
        exp_q.push_back({32'(cyc + 2), 2'(win), ref_mem[p_addr[win][9:0]]});
      end
      p_vld[win] = 1'b0;
      m_last = win;
    end
    if (m_locked) begin
      m_lk_cycles++;
      if (!lk[m_owner] || m_lk_cycles >= LOCK_MAX) begin
        m_norelock = lk[m_owner];
        m_norelock_id = m_owner;
        m_last = m_owner;
        m_locked = 1'b0;
      end
    end else if (win >= 0) begin
      if (lk[win] && !(m_norelock && win == m_norelock_id)) begin
        m_locked = 1'b1;
        m_owner = win;
        m_lk_cycles = 0;
      end
      m_norelock = 1'b0;
    end
  endtask

  // one arbitration cycle: entered and left at 1 time unit after a rising edge
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      req[i] = p_vld[i];
      req_we[i] = p_we[i];
      req_lock[i] = lk[i];
      req_addr[i*16 +: 16] = p_addr[i];
      req_wdata[i*16 +: 16] = p_wdata[i];
    end
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    lk = 3'b000;
    for (int i = 0; i < 8; i++) if (p_vld != 3'b000 || m_locked) tick();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_gnt"}, 32'(gnt), 32'd0);
    chk({pfx, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({pfx, "_bram_we"}, 32'(bram_we), 32'd0);
    chk({pfx, "_bram_addr"}, 32'(bram_addr), 32'd0);
    chk({pfx, "_bram_wdata"}, 32'(bram_wdata), 32'd0);
    chk({pfx, "_rdata"}, 32'(rdata), 32'd0);
    chk({pfx, "_owner"}, 32'(owner), 32'd3);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b000; req_we = 3'b000; req_lock = 3'b000;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      p_addr[i] = 16'h0;
      p_wdata[i] = 16'h0;
    end
    p_we = 3'b000;
    model_reset();
    pl_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pl_addr = 10'(i);
      pl_data = init_val(i);
      ref_mem[i] = init_val(i);
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // reset state, with every requester asserting
    req = 3'b111;
    #2;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single read of a preloaded word
    post(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    tick();
    chk("t1_addr", 32'(bram_addr), 32'h0010);
    tick();
    chk("t1_rvalid", 32'(rvalid), 32'b001);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    drain();

    // all three reading back to back: strict rotation after requester 0
    for (int k = 0; k < 9; k++) begin
      logic [2:0] seq [3];
      seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001;
      for (int i = 0; i < 3; i++) if (!p_vld[i]) post(i, 1'b0, 1'b0, 16'($urandom_range(0, 31)), 16'h0);
      tick();
      chk("t2_gnt", 32'(obs_gnt), 32'(seq[k % 3]));
    end
    drain();

    // write then read back through another requester
    post(1, 1'b1, 1'b0, 16'h0200, 16'h1234);
    tick();
    chk("t3_we_hi", 32'(bram_we), 32'd1);
    post(2, 1'b0, 1'b0, 16'h0200, 16'h0);
    tick();
    chk("t3_we_lo", 32'(bram_we), 32'd0);
    tick();
    chk("t3_rvalid", 32'(rvalid), 32'b100);
    chk("t3_rdata", 32'(rdata), 32'h1234);
    drain();

    // lock held until forced release
    post(1, 1'b0, 1'b1, 16'h0005, 16'h0);
    tick();
    post(0, 1'b0, 1'b0, 16'h0006, 16'h0);
    post(2, 1'b0, 1'b0, 16'h0007, 16'h0);
    for (int k = 0; k < LOCK_MAX; k++) begin
      post(1, 1'b0, 1'b1, 16'h0005, 16'h0);
      tick();
      chk("t4_gnt_owner", 32'(obs_gnt), 32'b010);
      chk("t4_owner", 32'(obs_owner), 32'd1);
    end
    p_vld[1] = 1'b0;
    lk[1] = 1'b0;
    tick();
    chk("t4_gnt_after", 32'(obs_gnt), 32'b100);
    chk("t4_owner_after", 32'(obs_owner), 32'd3);
    drain();

    // voluntary release by dropping req_lock
    post(1, 1'b0, 1'b1, 16'h0008, 16'h0);
    tick();
    lk[1] = 1'b0;
    post(0, 1'b0, 1'b0, 16'h0009, 16'h0);
    tick();
    chk("t5_gnt_rel", 32'(obs_gnt), 32'b000);
    chk("t5_owner_rel", 32'(obs_owner), 32'd1);
    tick();
    chk("t5_gnt_next", 32'(obs_gnt), 32'b001);
    chk("t5_owner_next", 32'(obs_owner), 32'd3);
    drain();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (m_locked && i == m_owner) lk[i] = ($urandom_range(0, 9) < 7);
        else lk[i] = ($urandom_range(0, 9) < 2);
        if (!p_vld[i] && $urandom_range(0, 1) == 1) post_rand(i);
      end
      tick();
    end
    drain();

    // asynchronous reset with a read in flight
    post(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    tick();
    #2;
    rst_n = 1'b0;
    req = 3'b111;
    #1;
    chk_reset_outputs("t6");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("t6_rvalid_hold", 32'(rvalid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) post(i, 1'b0, 1'b0, 16'($urandom_range(0, 31)), 16'h0);
    tick();
    chk("t6_first_gnt", 32'(obs_gnt), 32'b001);
    for (int k = 0; k < 4; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
